// File: rtl/wheel_meter_pkg.sv
// Shared FSM state type and width helpers for the wheel speed meter.
package wheel_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } meter_state_t;

  // One headroom bit lets a saturating add detect overflow before clamping.
  localparam int SAT_GUARD_W = 1;
  localparam int CIRC_W      = 32;
  localparam int REV_W       = 16;
  localparam int PROD_W      = REV_W + CIRC_W;

  function automatic int sum_w(input int w);
    return ((w > CIRC_W) ? w : CIRC_W) + SAT_GUARD_W;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus consecutive-sample debouncer for a reed input;
// rise is a one-cycle strobe one clock after the clean level goes high.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      // cnt tracks how many consecutive samples have disagreed with level
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wheel_speed_meter.sv
// Wheel distance/speed meter with stall detection.
// Optional signed accel output when WHEEL_SPEED_METER_ACCEL_EN is defined.
//
// state   | meaning
// IDLE    | gate held at 0, waiting for the first revolution
// MEASURE | gate counting windows, speed updated at each window close
// STALLED | too many empty windows, speed 0, gate stopped
module wheel_speed_meter
  import wheel_meter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CIRC_MM         = 2000,
  parameter int GATE_CYCLES     = 50_000_000,
  parameter int STALL_WINDOWS   = 3,
  parameter int DIST_W          = 24,
  parameter int SPD_W           = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iman,
  input  logic              clear,
  output logic [DIST_W-1:0] distance_mm,
  output logic [SPD_W-1:0]  speed,
  output logic              speed_valid,
  output logic              stalled,
  output logic              rev_pulse
`ifdef WHEEL_SPEED_METER_ACCEL_EN
  ,
  output logic signed [SPD_W:0] accel
`endif
);

  localparam int GATE_W  = $clog2(GATE_CYCLES + 1);
  localparam int EMPTY_W = $clog2(STALL_WINDOWS + 1);
  localparam int DSUM_W  = sum_w(DIST_W);

  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [EMPTY_W-1:0] EMPTY_LAST = EMPTY_W'(STALL_WINDOWS - 1);
  localparam logic [DSUM_W-1:0]  DIST_MAX   = DSUM_W'({DIST_W{1'b1}});
  localparam logic [PROD_W-1:0]  SPD_MAX    = PROD_W'({SPD_W{1'b1}});
  localparam logic [REV_W-1:0]   REV_MAX    = '1;

  meter_state_t       state;
  logic               rev;
  logic               clean_level;
  logic [GATE_W-1:0]  gate_cnt;
  logic [REV_W-1:0]   window_revs;
  logic [REV_W-1:0]   revs_total;
  logic [EMPTY_W-1:0] empty_cnt;
  logic [DSUM_W-1:0]  dist_sum;
  logic [PROD_W-1:0]  prod;
  logic [SPD_W-1:0]   speed_new;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (iman),
    .level  (clean_level),
    .rise   (rev)
  );

  assign rev_pulse = rev;

  // revs_total includes a pulse landing on the current cycle, so a pulse on
  // the terminal-count cycle is credited to the window being closed.
  always_comb begin
    revs_total = window_revs;
    if (rev && (window_revs != REV_MAX)) begin
      revs_total = window_revs + 1'b1;
    end
    dist_sum  = DSUM_W'(distance_mm) + DSUM_W'(CIRC_MM);
    prod      = PROD_W'(revs_total) * PROD_W'(CIRC_MM);
    speed_new = (prod > SPD_MAX) ? '1 : prod[SPD_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      window_revs <= '0;
      empty_cnt   <= '0;
      distance_mm <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      stalled     <= 1'b0;
`ifdef WHEEL_SPEED_METER_ACCEL_EN
      accel       <= '0;
`endif
    end else if (clear) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      window_revs <= '0;
      empty_cnt   <= '0;
      distance_mm <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (rev) begin
        distance_mm <= (dist_sum > DIST_MAX) ? '1 : dist_sum[DIST_W-1:0];
      end
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          if (rev) begin
            state       <= MEASURE;
            window_revs <= REV_W'(1);
          end
        end
        MEASURE: begin
          if (gate_cnt == GATE_LAST) begin
            gate_cnt    <= '0;
            window_revs <= '0;
            speed       <= speed_new;
            speed_valid <= 1'b1;
`ifdef WHEEL_SPEED_METER_ACCEL_EN
            accel       <= $signed({1'b0, speed_new}) - $signed({1'b0, speed});
`endif
            if (revs_total == '0) begin
              if (empty_cnt == EMPTY_LAST) begin
                state     <= STALLED;
                stalled   <= 1'b1;
                empty_cnt <= '0;
              end else begin
                empty_cnt <= empty_cnt + 1'b1;
              end
            end else begin
              empty_cnt <= '0;
            end
          end else begin
            gate_cnt    <= gate_cnt + 1'b1;
            window_revs <= revs_total;
          end
        end
        STALLED: begin
          gate_cnt <= '0;
          if (rev) begin
            state       <= MEASURE;
            stalled     <= 1'b0;
            window_revs <= REV_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          gate_cnt    <= '0;
          window_revs <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wheel_speed_meter.sv
// Self-checking bench for wheel_speed_meter: event-level reference model,
// per-cycle compare, directed literal pins and a randomized soak.
`timescale 1ns/1ps
module tb_wheel_speed_meter;

  localparam int DEB      = 4;
  localparam int CIRC     = 2000;
  localparam int GATE     = 100;
  localparam int STALLW   = 2;
  localparam int DW       = 16;
  localparam int SW       = 16;
  localparam int GATE_SAT = 500;
  localparam int DMAX     = 65535;
  localparam int SMAX     = 65535;

  logic          clock;
  logic          reset_n;
  logic          iman;
  logic          clear;
  logic [DW-1:0] distance_mm;
  logic [SW-1:0] speed;
  logic          speed_valid;
  logic          stalled;
  logic          rev_pulse;
  logic [DW-1:0] sat_distance;
  logic [SW-1:0] sat_speed;
  logic          sat_valid;
  logic          sat_stalled;
  logic          sat_rev;
`ifdef WHEEL_SPEED_METER_ACCEL_EN
  logic signed [SW:0] accel;
  logic signed [SW:0] sat_accel;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  wheel_speed_meter #(
    .DEBOUNCE_CYCLES(DEB), .CIRC_MM(CIRC), .GATE_CYCLES(GATE),
    .STALL_WINDOWS(STALLW), .DIST_W(DW), .SPD_W(SW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .iman(iman), .clear(clear),
    .distance_mm(distance_mm), .speed(speed), .speed_valid(speed_valid),
    .stalled(stalled), .rev_pulse(rev_pulse)
`ifdef WHEEL_SPEED_METER_ACCEL_EN
    , .accel(accel)
`endif
  );

  // Long-window instance so 40 revolutions fit into a single window.
  wheel_speed_meter #(
    .DEBOUNCE_CYCLES(DEB), .CIRC_MM(CIRC), .GATE_CYCLES(GATE_SAT),
    .STALL_WINDOWS(STALLW), .DIST_W(DW), .SPD_W(SW)
  ) u_sat (
    .clock(clock), .reset_n(reset_n), .iman(iman), .clear(clear),
    .distance_mm(sat_distance), .speed(sat_speed), .speed_valid(sat_valid),
    .stalled(sat_stalled), .rev_pulse(sat_rev)
`ifdef WHEEL_SPEED_METER_ACCEL_EN
    , .accel(sat_accel)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  // Clean level flips once the last DEB synchronized samples all disagree
  // with it; rev follows one clock after a rising flip. Windows are tracked
  // by absolute edge number rather than a gate counter.
  bit hist[$];
  bit m_clean = 0, m_rose = 0, m_rev = 0, m_valid = 0, m_stalled = 0;
  int m_dist = 0, m_speed = 0, m_accel = 0;
  int m_mode = 0;          // 0 idle, 1 measuring, 2 stalled
  int m_revs = 0, m_empty = 0;
  longint edge_no = 0, win_end = 0;
  bit r_now, flip;
  int tot, spd;

  always @(posedge clock) begin
    edge_no++;
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_front(1'b0);
      m_clean = 0; m_rose = 0; m_rev = 0; m_valid = 0; m_stalled = 0;
      m_dist = 0; m_speed = 0; m_accel = 0; m_mode = 0; m_revs = 0; m_empty = 0;
    end else begin
      r_now = m_rev;
      flip = 1;
      for (int i = 1; i <= DEB; i++) if (hist[i] == m_clean) flip = 0;
      m_rev  = m_rose;
      m_rose = flip && !m_clean;
      if (flip) m_clean = !m_clean;
      hist.push_front(iman);
      void'(hist.pop_back());

      if (clear) begin
        m_dist = 0; m_speed = 0; m_valid = 0; m_stalled = 0;
        m_mode = 0; m_revs = 0; m_empty = 0;
      end else begin
        m_valid = 0;
        if (r_now) m_dist = (m_dist + CIRC > DMAX) ? DMAX : m_dist + CIRC;
        if (m_mode != 1) begin
          if (r_now) begin
            m_mode = 1; m_stalled = 0; m_revs = 1; win_end = edge_no + GATE;
          end
        end else begin
          m_revs += int'(r_now);
          if (edge_no == win_end) begin
            spd = (m_revs * CIRC > SMAX) ? SMAX : m_revs * CIRC;
            m_accel = spd - m_speed;
            m_speed = spd;
            m_valid = 1;
            win_end = edge_no + GATE;
            if (m_revs == 0) begin
              m_empty++;
              if (m_empty == STALLW) begin
                m_mode = 2; m_stalled = 1; m_empty = 0;
              end
            end else begin
              m_empty = 0;
            end
            m_revs = 0;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("rev_pulse", rev_pulse, m_rev);
      check("distance_mm", distance_mm, m_dist);
      check("speed", speed, m_speed);
      check("speed_valid", speed_valid, m_valid);
      check("stalled", stalled, m_stalled);
      check("sat_rev_pulse", sat_rev, m_rev);
`ifdef WHEEL_SPEED_METER_ACCEL_EN
      if (m_valid) check("accel", 64'($signed(accel)), m_accel);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rev_cycle(input int hi, input int lo);
    iman = 1'b1;
    repeat (hi) tick();
    iman = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (speed_valid) begin ok = 1; break; end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int  first, pulses, p0, events;
  bit  ok;

  initial begin
    reset_n = 1'b0; iman = 1'b0; clear = 1'b0;
    repeat (3) tick();
    chk_en = 1;
    check("reset_distance", distance_mm, 0);
    check("reset_speed", speed, 0);
    check("reset_valid", speed_valid, 0);
    check("reset_stalled", stalled, 0);
    check("reset_rev", rev_pulse, 0);
    reset_n = 1'b1;
    tick();

    // Glitch: 3 cycles high is rejected.
    pulses = 0;
    iman = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 3) iman = 1'b0;
      if (rev_pulse) pulses++;
    end
    check("glitch_no_pulse", pulses, 0);

    // Stable edge: one pulse, 7 cycles later.
    first = -1; pulses = 0;
    iman = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) iman = 1'b0;
      if (rev_pulse) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("edge_latency", first, 7);
    check("edge_one_pulse", pulses, 1);

    // Rate: 3 revs then 1 rev.
    do_clear();
    repeat (3) rev_cycle(6, 6);
    wait_valid(200, ok);
    check("rate_valid_seen", ok, 1);
    check("rate_speed_3rev", speed, 6000);
    tick();
    check("rate_valid_one_cycle", speed_valid, 0);
    rev_cycle(6, 6);
    wait_valid(200, ok);
    check("rate_valid2_seen", ok, 1);
    check("rate_speed_1rev", speed, 2000);
`ifdef WHEEL_SPEED_METER_ACCEL_EN
    check("accel_6000_to_2000", 64'($signed(accel)), -4000);
`endif

    // Distance saturation.
    do_clear();
    repeat (33) rev_cycle(6, 6);
    check("dist_sat_33", distance_mm, 65535);
    rev_cycle(6, 6);
    check("dist_sat_hold", distance_mm, 65535);

    // Speed saturation on the long-window instance.
    do_clear();
    repeat (40) rev_cycle(5, 5);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (sat_valid) begin ok = 1; break; end
      tick();
    end
    check("sat_valid_seen", ok, 1);
    check("sat_speed_40rev", sat_speed, 65535);
    check("sat_distance_40rev", sat_distance, 65535);
    check("sat_not_stalled", sat_stalled, 0);

    // Stall and recovery.
    do_clear();
    rev_cycle(6, 6);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (stalled) begin ok = 1; break; end
      tick();
    end
    check("stall_seen", ok, 1);
    check("stall_speed_zero", speed, 0);
    iman = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rev_pulse) begin ok = 1; break; end
    end
    check("stall_pulse_seen", ok, 1);
    check("stall_high_on_pulse", stalled, 1);
    tick();
    check("stall_released", stalled, 0);
    iman = 1'b0;
    repeat (8) tick();

    // Pulse on the terminal-count cycle belongs to the closing window.
    do_clear();
    iman = 1'b1; p0 = -1;
    for (int i = 1; i <= 130; i++) begin
      tick();
      if (i == 6) iman = 1'b0;
      if (rev_pulse && p0 < 0) p0 = i;
      if (p0 > 0 && i == p0 + 93) iman = 1'b1;
      if (p0 > 0 && i == p0 + 99) iman = 1'b0;
      if (p0 > 0 && i == p0 + 100) check("tc_pulse_present", rev_pulse, 1);
      if (p0 > 0 && i == p0 + 101) begin
        check("tc_valid", speed_valid, 1);
        check("tc_speed_2rev", speed, 4000);
      end
    end
    check("tc_first_pulse", p0, 7);

    // Clear together with a pulse.
    do_clear();
    rev_cycle(6, 6);
    check("clr_pre_distance", distance_mm, 2000);
    iman = 1'b1;
    repeat (7) tick();
    check("clr_pulse_present", rev_pulse, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    iman = 1'b0;
    check("clr_distance", distance_mm, 0);
    check("clr_speed", speed, 0);
    check("clr_stalled", stalled, 0);
    check("clr_valid", speed_valid, 0);
    events = 0;
    repeat (300) begin
      tick();
      if (speed_valid || stalled) events++;
    end
    check("clr_stays_idle", events, 0);

    // Reset mid-window.
    do_clear();
    iman = 1'b1;
    repeat (7) tick();
    iman = 1'b0;
    repeat (50) tick();
    reset_n = 1'b0;
    tick();
    check("rst_distance", distance_mm, 0);
    check("rst_speed", speed, 0);
    check("rst_valid", speed_valid, 0);
    check("rst_stalled", stalled, 0);
    reset_n = 1'b1;
    events = 0;
    repeat (200) begin
      tick();
      if (speed_valid) events++;
    end
    check("rst_no_valid", events, 0);

    // Randomized soak against the model.
    for (int seg = 0; seg < 400; seg++) begin
      iman = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) begin
        clear   = ($urandom_range(0, 299) == 0);
        reset_n = ($urandom_range(0, 999) != 0);
        tick();
      end
    end
    clear = 1'b0; reset_n = 1'b1; iman = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wheel_speed_meter.md
WHEEL_SPEED_METER -- requirements
Module: wheel_speed_meter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable samples needed to accept a magnet-input change.
REQ-002 Parameter CIRC_MM, default 2000, is the wheel circumference in mm added per revolution.
REQ-003 Parameter GATE_CYCLES, default 50_000_000, is the length of the speed measurement window in clocks.
REQ-004 Parameter STALL_WINDOWS, default 3, is the number of consecutive empty windows before the meter declares a stall.
REQ-005 Parameter DIST_W, default 24, is the width of the distance output; parameter SPD_W, default 16, is the width of the speed output.
REQ-006 clock  in  1  single system clock; all logic is on its rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 iman  in  1  asynchronous raw magnet (reed) sensor input.
REQ-009 clear  in  1  synchronous request to zero distance and speed.
REQ-010 distance_mm  out  DIST_W  accumulated distance in mm.
REQ-011 speed  out  SPD_W  mm travelled in the last completed window.
REQ-012 speed_valid  out  1  one-cycle strobe when speed updates.
REQ-013 stalled  out  1  high while the wheel is considered stopped.
REQ-014 rev_pulse  out  1  one-cycle strobe per accepted revolution.

Function
REQ-015 iman SHALL pass through a 2-flop synchronizer, then a debouncer that changes the clean level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-016 A 0->1 transition of the clean level SHALL produce rev_pulse for exactly one cycle, with 2+DEBOUNCE_CYCLES+1 cycles latency from a stable iman edge.
REQ-017 On each rev_pulse, distance_mm SHALL add CIRC_MM and saturate at 2^DIST_W-1; it SHALL never wrap.
REQ-018 The FSM states SHALL be IDLE, MEASURE and STALLED; reset enters IDLE.
REQ-019 In IDLE the gate counter SHALL be held at 0; the first rev_pulse SHALL move the FSM to MEASURE, and that pulse SHALL count in the first window.
REQ-020 In MEASURE the gate counter SHALL run 0..GATE_CYCLES-1; at terminal count the meter SHALL load speed = window_revs*CIRC_MM (saturated to 2^SPD_W-1), pulse speed_valid in the next cycle, and zero window_revs.
REQ-021 A rev_pulse on the terminal-count cycle SHALL be counted in the window being closed.
REQ-022 After STALL_WINDOWS consecutive windows with zero revolutions, the FSM SHALL enter STALLED, assert stalled, hold speed at 0 and stop the gate counter.
REQ-023 A rev_pulse in STALLED SHALL deassert stalled in the next cycle and return the FSM to MEASURE with a fresh window containing that pulse.
REQ-024 clear SHALL zero distance_mm, speed, window_revs and the gate counter and force the FSM to IDLE; clear overrides a simultaneous rev_pulse, which is discarded.

Reset
REQ-025 With reset_n=0 at a clock edge, all outputs SHALL become 0, the FSM SHALL enter IDLE, the debouncer clean level SHALL be 0 and its counters SHALL clear.
REQ-026 A reset asserted mid-window SHALL discard the partial window and SHALL NOT produce speed_valid.

Configuration
REQ-027 With WHEEL_SPEED_METER_ACCEL_EN defined, the block SHALL add an output accel (signed, SPD_W+1 bits) equal to the new speed minus the previous speed, updated with speed_valid and reset to 0; without the macro, the port and its logic SHALL be absent.

Structure
REQ-028 The FSM state enum and the saturating-add width helper constants SHALL live in the shared package wheel_meter_pkg.
REQ-029 The synchronizer and debouncer SHALL form one sub-module, sensor_debounce, that can be instantiated on its own.

Verification (DEBOUNCE_CYCLES=4, CIRC_MM=2000, GATE_CYCLES=100, STALL_WINDOWS=2, DIST_W=16, SPD_W=16)
REQ-030 Glitch: iman high for 3 cycles, then low -> no rev_pulse; iman high for 10 cycles -> one rev_pulse 7 cycles after the edge.
REQ-031 Rate: 3 clean revolutions within one window -> speed=6000 with a one-cycle speed_valid; the next window with 1 revolution -> speed=2000.
REQ-032 Saturation: 33 revolutions -> distance_mm=65535 and holds; 40 revolutions in one window -> speed=65535.
REQ-033 Stall: 2 empty windows -> stalled=1 and speed=0; the next revolution -> stalled=0 the following cycle.
REQ-034 Boundary: rev_pulse on the terminal-count cycle -> counted in the closing window; clear together with rev_pulse -> all outputs 0 and FSM in IDLE.
REQ-035 Reset mid-window (cycle 50) -> all outputs 0 and no speed_valid; with the ACCEL macro, speeds 6000 then 2000 -> accel=-4000.
